// File: rtl/ras_predecode.sv
// ras_predecode: fetch-stage predecoder that drives RAS push/pop and registers the predicted next PC.
// Optional macro BTFN_EN predicts backward conditional branches as taken.
module ras_predecode #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned LINK_A = 1,
  parameter int unsigned LINK_B = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            pd_valid,
  input  logic            pd_ready,
  output logic [XLEN-1:0] pd_pc,
  output logic [31:0]     pd_instr,
  output logic [XLEN-1:0] pd_npc,
  output logic            pd_taken,
  output logic [1:0]      pd_kind,
  output logic            ras_push,
  output logic            ras_pop,
  output logic [XLEN-1:0] ras_wdata,
  input  logic [XLEN-1:0] ras_rdata,
  input  logic            ras_rvalid
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] KIND_OTHER  = 2'b00;
  localparam logic [1:0] KIND_CALL   = 2'b01;
  localparam logic [1:0] KIND_RET    = 2'b10;
  localparam logic [1:0] KIND_COROUT = 2'b11;

  typedef enum logic {S_RUN, S_SWAP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] swap_ra_q;

  logic [6:0]      opcode_c;
  logic [4:0]      rd_c, rs1_c;
  logic            link_rd_c, link_rs1_c;
  logic [XLEN-1:0] pc_plus4_c, imm_j_c;
  logic [1:0]      kind_c;
  logic            want_push_c, want_pop_c, want_swap_c;
  logic [XLEN-1:0] npc_c;
  logic            taken_c;
  logic            acc_c;

  assign opcode_c   = if_instr[6:0];
  assign rd_c       = if_instr[11:7];
  assign rs1_c      = if_instr[19:15];
  assign link_rd_c  = (rd_c == 5'(LINK_A)) || (rd_c == 5'(LINK_B));
  assign link_rs1_c = (rs1_c == 5'(LINK_A)) || (rs1_c == 5'(LINK_B));
  assign pc_plus4_c = if_pc + XLEN'(4);
  assign imm_j_c    = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                       if_instr[20], if_instr[30:21], 1'b0};

`ifdef BTFN_EN
  logic [XLEN-1:0] imm_b_c;
  assign imm_b_c = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
`endif

  // Classify the fetched word and form its prediction
  always_comb begin
    kind_c      = KIND_OTHER;
    want_push_c = 1'b0;
    want_pop_c  = 1'b0;
    want_swap_c = 1'b0;
    npc_c       = pc_plus4_c;
    taken_c     = 1'b0;
    if (opcode_c == OP_JAL) begin
      npc_c   = if_pc + imm_j_c;
      taken_c = 1'b1;
      if (link_rd_c) begin
        kind_c      = KIND_CALL;
        want_push_c = 1'b1;
      end
    end else if (opcode_c == OP_JALR) begin
      if (link_rd_c && link_rs1_c && (rd_c != rs1_c)) begin
        kind_c      = KIND_COROUT;
        want_pop_c  = 1'b1;
        want_swap_c = 1'b1;
      end else if (link_rd_c) begin
        kind_c      = KIND_CALL;
        want_push_c = 1'b1;
      end else if (link_rs1_c) begin
        kind_c     = KIND_RET;
        want_pop_c = 1'b1;
      end
      // Target of a pop comes from the stack only when the stack had an entry
      if (want_pop_c && ras_rvalid) begin
        npc_c   = ras_rdata;
        taken_c = 1'b1;
      end
    end else if (opcode_c == OP_BRANCH) begin
`ifdef BTFN_EN
      if (if_instr[31]) begin
        npc_c   = if_pc + imm_b_c;
        taken_c = 1'b1;
      end
`endif
    end
  end

  // Handshake, RAS requests and next state
  always_comb begin
    state_d   = state_q;
    if_ready  = 1'b0;
    acc_c     = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_wdata = pc_plus4_c;
    unique case (state_q)
      S_RUN: begin
        if_ready = !rst && (!pd_valid || pd_ready) && !flush;
        acc_c    = if_valid && !rst && (!pd_valid || pd_ready) && !flush;
        ras_push = acc_c && want_push_c;
        ras_pop  = acc_c && want_pop_c;
        if (acc_c && want_swap_c) state_d = S_SWAP;
      end
      S_SWAP: begin
        ras_push  = !flush && !rst;
        ras_wdata = swap_ra_q;
        state_d   = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (flush) state_d = S_RUN;
  end

  // State and output-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      swap_ra_q <= '0;
      pd_valid  <= 1'b0;
      pd_pc     <= '0;
      pd_instr  <= '0;
      pd_npc    <= '0;
      pd_taken  <= 1'b0;
      pd_kind   <= KIND_OTHER;
    end else begin
      state_q <= state_d;
      if (flush)         pd_valid <= 1'b0;
      else if (acc_c)    pd_valid <= 1'b1;
      else if (pd_ready) pd_valid <= 1'b0;
      if (acc_c) begin
        pd_pc    <= if_pc;
        pd_instr <= if_instr;
        pd_npc   <= npc_c;
        pd_taken <= taken_c;
        pd_kind  <= kind_c;
      end
      if (acc_c && want_swap_c) swap_ra_q <= pc_plus4_c;
    end
  end

endmodule

// File: tb/tb_ras_predecode.sv
// Self-checking bench for ras_predecode: directed vector table, hand sequences for
// coroutine/backpressure/flush, then random traffic against a behavioural model.
module tb_ras_predecode;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, pd_valid, pd_ready, pd_taken;
  logic        ras_push, ras_pop, ras_rvalid;
  logic [63:0] if_pc, pd_pc, pd_npc, ras_wdata, ras_rdata;
  logic [31:0] if_instr, pd_instr;
  logic [1:0]  pd_kind;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ras_predecode dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .pd_valid(pd_valid), .pd_ready(pd_ready),
    .pd_pc(pd_pc), .pd_instr(pd_instr), .pd_npc(pd_npc), .pd_taken(pd_taken),
    .pd_kind(pd_kind), .ras_push(ras_push), .ras_pop(ras_pop), .ras_wdata(ras_wdata),
    .ras_rdata(ras_rdata), .ras_rvalid(ras_rvalid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] rdata;
    logic        rvalid;
    logic        push, pop;
    logic [63:0] wdata, npc;
    logic        taken;
    logic [1:0]  kind;
  } vec_t;

  typedef struct {
    logic        push, pop, swap, taken;
    logic [63:0] npc;
    logic [1:0]  kind;
  } pred_t;

  // Reference prediction written from the ISA rules with signed arithmetic
  function automatic pred_t predict(input logic [63:0] pc, input logic [31:0] ins,
                                    input logic [63:0] rdata, input logic rvalid);
    pred_t p;
    int unsigned rd, rs1;
    bit lrd, lrs;
    logic [20:0] j21;
    logic [12:0] b13;
    longint off;
    rd  = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    lrd = (rd == 1) || (rd == 5);
    lrs = (rs1 == 1) || (rs1 == 5);
    p = '{push: 1'b0, pop: 1'b0, swap: 1'b0, taken: 1'b0, npc: pc + 64'd4, kind: 2'd0};
    if (ins[6:0] == 7'h6F) begin
      j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      off = longint'($signed(j21));
      p.npc = pc + 64'(off);
      p.taken = 1'b1;
      if (lrd) begin p.kind = 2'd1; p.push = 1'b1; end
    end else if (ins[6:0] == 7'h67) begin
      if (lrd && lrs && rd != rs1) begin p.kind = 2'd3; p.pop = 1'b1; p.swap = 1'b1; end
      else if (lrd) begin p.kind = 2'd1; p.push = 1'b1; end
      else if (lrs) begin p.kind = 2'd2; p.pop = 1'b1; end
      if (p.pop && rvalid) begin p.npc = rdata; p.taken = 1'b1; end
    end else if (ins[6:0] == 7'h63) begin
      b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      off = longint'($signed(b13));
`ifdef BTFN_EN
      if (off < 0) begin p.npc = pc + 64'(off); p.taken = 1'b1; end
`endif
    end
    return p;
  endfunction

`ifdef BTFN_EN
  localparam logic [63:0] BEQ_NPC = 64'h3FF8;
  localparam logic        BEQ_TKN = 1'b1;
`else
  localparam logic [63:0] BEQ_NPC = 64'h4004;
  localparam logic        BEQ_TKN = 1'b0;
`endif

  vec_t vecs[12];

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic [63:0] rd, input logic rv);
    if_valid = v; if_pc = pc; if_instr = ins; ras_rdata = rd; ras_rvalid = rv;
  endtask

  // Behavioural model state for the random phase
  bit          m_v, m_swap, m_taken;
  logic [63:0] m_pc, m_npc, m_ra;
  logic [31:0] m_instr;
  logic [1:0]  m_kind;

  initial begin
    vecs[0]  = '{64'h1000, 32'h100000EF, 64'h0, 1'b0, 1'b1, 1'b0, 64'h1004, 64'h1100, 1'b1, 2'd1};
    vecs[1]  = '{64'h2000, 32'h00008067, 64'h1004, 1'b1, 1'b0, 1'b1, 64'h0, 64'h1004, 1'b1, 2'd2};
    vecs[2]  = '{64'h2000, 32'h00008067, 64'h1004, 1'b0, 1'b0, 1'b1, 64'h0, 64'h2004, 1'b0, 2'd2};
    vecs[3]  = '{64'h4000, 32'hFE000CE3, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, BEQ_NPC, BEQ_TKN, 2'd0};
    vecs[4]  = '{64'h5000, 32'hFFDFF06F, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4FFC, 1'b1, 2'd0};
    vecs[5]  = '{64'h6000, 32'h000500E7, 64'h0, 1'b1, 1'b1, 1'b0, 64'h6004, 64'h6004, 1'b0, 2'd1};
    vecs[6]  = '{64'h7000, 32'h000282E7, 64'h0, 1'b1, 1'b1, 1'b0, 64'h7004, 64'h7004, 1'b0, 2'd1};
    vecs[7]  = '{64'h8000, 32'h00030067, 64'h99, 1'b1, 1'b0, 1'b0, 64'h0, 64'h8004, 1'b0, 2'd0};
    vecs[8]  = '{64'h9000, 32'h00028067, 64'hDEAD0000, 1'b1, 1'b0, 1'b1, 64'h0, 64'hDEAD0000, 1'b1, 2'd2};
    vecs[9]  = '{64'hA000, 32'h00000013, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'hA004, 1'b0, 2'd0};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FF00, 32'h100000EF, 64'h0, 1'b0, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FF04, 64'h0, 1'b1, 2'd1};
    vecs[11] = '{64'hB000, 32'h00008067, 64'h1236, 1'b1, 1'b0, 1'b1, 64'h0, 64'h1236, 1'b1, 2'd2};

    // Reset with a call offered: no RAS traffic, no acceptance
    rst = 1'b1; flush = 1'b0; pd_ready = 1'b1;
    drive(1'b1, 64'h1000, 32'h100000EF, 64'h0, 1'b0);
    @(negedge clk); #1;
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_push", 64'(ras_push), 64'd0);
    chk("rst_pop", 64'(ras_pop), 64'd0);
    @(posedge clk); #1;
    chk("rst_pd_valid", 64'(pd_valid), 64'd0);
    chk("rst_pd_pc", pd_pc, 64'd0);
    chk("rst_pd_npc", pd_npc, 64'd0);
    chk("rst_pd_instr", 64'(pd_instr), 64'd0);
    chk("rst_pd_taken", 64'(pd_taken), 64'd0);
    chk("rst_pd_kind", 64'(pd_kind), 64'd0);
    @(negedge clk); rst = 1'b0; if_valid = 1'b0;

    // Directed vector table, one accepted word per cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].pc, vecs[i].instr, vecs[i].rdata, vecs[i].rvalid);
      #1;
      chk($sformatf("v%0d_if_ready", i), 64'(if_ready), 64'd1);
      chk($sformatf("v%0d_push", i), 64'(ras_push), 64'(vecs[i].push));
      chk($sformatf("v%0d_pop", i), 64'(ras_pop), 64'(vecs[i].pop));
      if (vecs[i].push) chk($sformatf("v%0d_wdata", i), ras_wdata, vecs[i].wdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pd_valid", i), 64'(pd_valid), 64'd1);
      chk($sformatf("v%0d_pd_pc", i), pd_pc, vecs[i].pc);
      chk($sformatf("v%0d_pd_instr", i), 64'(pd_instr), 64'(vecs[i].instr));
      chk($sformatf("v%0d_pd_npc", i), pd_npc, vecs[i].npc);
      chk($sformatf("v%0d_pd_taken", i), 64'(pd_taken), 64'(vecs[i].taken));
      chk($sformatf("v%0d_pd_kind", i), 64'(pd_kind), 64'(vecs[i].kind));
    end

    // Coroutine: pop now, push latched pc+4 next cycle with fetch stalled
    @(negedge clk);
    drive(1'b1, 64'h3000, 32'h000280E7, 64'h1234, 1'b1);
    #1;
    chk("co_pop", 64'(ras_pop), 64'd1);
    chk("co_push_t0", 64'(ras_push), 64'd0);
    @(posedge clk); #1;
    if_valid = 1'b0;
    #1;
    chk("co_pd_npc", pd_npc, 64'h1234);
    chk("co_pd_kind", 64'(pd_kind), 64'd3);
    chk("co_pd_taken", 64'(pd_taken), 64'd1);
    chk("co_swap_push", 64'(ras_push), 64'd1);
    chk("co_swap_pop", 64'(ras_pop), 64'd0);
    chk("co_swap_wdata", ras_wdata, 64'h3004);
    chk("co_swap_ready", 64'(if_ready), 64'd0);
    @(posedge clk); #1;
    chk("co_t2_ready", 64'(if_ready), 64'd1);
    chk("co_t2_push", 64'(ras_push), 64'd0);

    // Backpressure: held stage blocks a call for three cycles
    @(negedge clk);
    pd_ready = 1'b0;
    drive(1'b1, 64'hC000, 32'h00000013, 64'h0, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 64'hD000, 32'h100000EF, 64'h0, 1'b0);
      #1;
      chk($sformatf("bp%0d_ready", k), 64'(if_ready), 64'd0);
      chk($sformatf("bp%0d_push", k), 64'(ras_push), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), 64'(pd_valid), 64'd1);
      chk($sformatf("bp%0d_pc", k), pd_pc, 64'hC000);
      chk($sformatf("bp%0d_npc", k), pd_npc, 64'hC004);
    end

    // Flush while in SWAP drops the pending push and empties the stage
    @(negedge clk);
    pd_ready = 1'b1;
    drive(1'b1, 64'hE000, 32'h000280E7, 64'h5550, 1'b1);
    #1;
    chk("fl_accept", 64'(if_ready), 64'd1);
    chk("fl_pop", 64'(ras_pop), 64'd1);
    @(negedge clk);
    if_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl_swap_push", 64'(ras_push), 64'd0);
    chk("fl_swap_ready", 64'(if_ready), 64'd0);
    @(posedge clk); #1;
    chk("fl_pd_valid", 64'(pd_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_after_ready", 64'(if_ready), 64'd1);
    chk("fl_after_push", 64'(ras_push), 64'd0);

    // Random traffic against the behavioural model
    m_v = 1'b0; m_swap = 1'b0;
    m_pc = '0; m_npc = '0; m_instr = '0; m_taken = 1'b0; m_kind = '0; m_ra = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] ins;
      logic [4:0]  regs[4];
      pred_t p;
      bit rdy, acc, e_push;
      @(negedge clk);
      ins = $urandom;
      case ($urandom_range(0, 4))
        0: ins[6:0] = 7'h6F;
        1, 2: ins[6:0] = 7'h67;
        3: ins[6:0] = 7'h63;
        default: ;
      endcase
      regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'($urandom);
      ins[11:7]  = regs[$urandom_range(0, 3)];
      ins[19:15] = regs[$urandom_range(0, 3)];
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, ins,
            {$urandom, $urandom}, 1'($urandom));
      pd_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      #1;
      p      = predict(if_pc, if_instr, ras_rdata, ras_rvalid);
      rdy    = !m_swap && (!m_v || pd_ready) && !flush;
      acc    = if_valid && rdy;
      e_push = m_swap ? !flush : (acc && p.push);
      chk("rnd_ready", 64'(if_ready), 64'(rdy));
      chk("rnd_push", 64'(ras_push), 64'(e_push));
      chk("rnd_pop", 64'(ras_pop), 64'(acc && p.pop));
      if (e_push) chk("rnd_wdata", ras_wdata, m_swap ? m_ra : if_pc + 64'd4);
      if (flush) m_v = 1'b0;
      else if (acc) begin
        m_v = 1'b1; m_pc = if_pc; m_instr = if_instr;
        m_npc = p.npc; m_taken = p.taken; m_kind = p.kind;
      end else if (pd_ready) m_v = 1'b0;
      m_swap = !flush && acc && p.swap;
      if (acc && p.swap) m_ra = if_pc + 64'd4;
      @(posedge clk); #1;
      chk("rnd_pd_valid", 64'(pd_valid), 64'(m_v));
      if (m_v) begin
        chk("rnd_pd_pc", pd_pc, m_pc);
        chk("rnd_pd_instr", 64'(pd_instr), 64'(m_instr));
        chk("rnd_pd_npc", pd_npc, m_npc);
        chk("rnd_pd_taken", 64'(pd_taken), 64'(m_taken));
        chk("rnd_pd_kind", 64'(pd_kind), 64'(m_kind));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
